// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
package display_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    typedef struct packed {
        logic       found;
        logic [4:0] index;
    } bit_pos_t;

    // Lowest set bit of mask at position >= from.
    function automatic bit_pos_t next_set_bit(input logic [MAX_DIGITS-1:0] mask,
                                              input int unsigned from);
        bit_pos_t r;
        r = '0;
        for (int unsigned i = MAX_DIGITS; i > 0; i--) begin
            if (mask[i-1] && ((i - 1) >= from)) begin
                r.found = 1'b1;
                r.index = 5'(i - 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/module_dwell_timer.sv
// Dwell counter: restarts from zero on start, flags the last cycle of a len-cycle interval.
module module_dwell_timer #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] len,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        done = (cnt == (len - CW'(1)));
    end

endmodule

// File: rtl/module_display_scheduler.sv
// Scans enabled digits with a dark guard interval before each; new data/mask is
// buffered through a valid/ready shadow register and only committed at frame boundaries.
module module_display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned WAIT_TIME  = 27000,
    parameter int unsigned BLANK_TIME = 16,
    parameter int unsigned DIGITS     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BCD_W*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]         mask_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    output logic [DIGITS-1:0]         sel_o,
    output logic [BCD_W-1:0]          digit_o,
    output logic                      frame_done_o
);

    localparam int unsigned MAXT = (WAIT_TIME > BLANK_TIME) ? WAIT_TIME : BLANK_TIME;
    localparam int unsigned CW   = $clog2(MAXT + 1);
    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                    state;
    logic [BCD_W*DIGITS-1:0]   act_data, pend_data, commit_data, ent_data;
    logic [DIGITS-1:0]         act_mask, pend_mask, commit_mask;
    logic                      full;
    logic [IW-1:0]             idx, ent_idx;
    logic [DIGITS-1:0]         ent_sel, cur_sel;
    logic [BCD_W-1:0]          ent_digit;
    logic [CW-1:0]             len;
    logic                      done, start;
    int unsigned               idx_next;
    bit_pos_t                  nxt, first;

    // The entry target is the next digit within the frame, or else the first digit
    // of whatever mask is live after a possible commit.
    always_comb begin
        commit_mask = full ? pend_mask : act_mask;
        commit_data = full ? pend_data : act_data;
        idx_next    = 32'(idx) + 32'd1;
        nxt         = next_set_bit(MAX_DIGITS'(act_mask), idx_next);
        first       = next_set_bit(MAX_DIGITS'(commit_mask), 0);
        if ((state == SHOW) && nxt.found) begin
            ent_idx  = IW'(nxt.index);
            ent_data = act_data;
        end else begin
            ent_idx  = IW'(first.index);
            ent_data = commit_data;
        end
        ent_digit = ent_data[BCD_W*ent_idx +: BCD_W];
        ent_sel   = DIGITS'(1) << ent_idx;
        cur_sel   = DIGITS'(1) << idx;
        len       = (state == BLANK) ? CW'(BLANK_TIME) : CW'(WAIT_TIME);
        start     = (state == IDLE) || done;
    end

    module_dwell_timer #(
        .CW(CW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .len  (len),
        .done (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sel_o        <= '0;
            digit_o      <= '0;
            frame_done_o <= 1'b0;
            load_ready_o <= 1'b1;
            act_data     <= '0;
            act_mask     <= '0;
            pend_data    <= '0;
            pend_mask    <= '0;
            full         <= 1'b0;
            idx          <= '0;
        end else begin
            frame_done_o <= 1'b0;
            if (load_valid_i && load_ready_o) begin
                pend_data    <= data_i;
                pend_mask    <= mask_i;
                full         <= 1'b1;
                load_ready_o <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    sel_o <= '0;
                    if (full) begin
                        act_data     <= pend_data;
                        act_mask     <= pend_mask;
                        full         <= 1'b0;
                        load_ready_o <= 1'b1;
                        if (first.found) begin
                            idx     <= ent_idx;
                            digit_o <= ent_digit;
                            state   <= (BLANK_TIME == 0) ? SHOW : BLANK;
                            sel_o   <= (BLANK_TIME == 0) ? ent_sel : '0;
                        end
                    end
                end
                BLANK: begin
                    if (done) begin
                        state <= SHOW;
                        sel_o <= cur_sel;
                    end
                end
                SHOW: begin
                    if (done) begin
                        if (!nxt.found) begin
                            frame_done_o <= 1'b1;
                            if (full) begin
                                act_data     <= pend_data;
                                act_mask     <= pend_mask;
                                full         <= 1'b0;
                                load_ready_o <= 1'b1;
                            end
                        end
                        if (nxt.found || first.found) begin
                            idx     <= ent_idx;
                            digit_o <= ent_digit;
                            state   <= (BLANK_TIME == 0) ? SHOW : BLANK;
                            sel_o   <= (BLANK_TIME == 0) ? ent_sel : '0;
                        end else begin
                            state <= IDLE;
                            sel_o <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sel_o <= '0;
                end
            endcase
        end
    end

endmodule
